// File: rtl/pool2d_if.sv
// Stream bundle for pool2d_stream: pixel input channel, pooled output channel
// and the per-frame mode select.
interface pool2d_if #(
    parameter int DATA_W = 32
);
    logic                     mode;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_ready;
    logic                     out_last;
    logic                     frame_done;

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, frame_done
    );

    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, frame_done
    );
endinterface

// File: rtl/pool2d_stream.sv
// Streaming 2x2 / stride-2 max or average pooling over a raster-order pixel
// stream, holding one input row in a buffer.
module pool2d_stream #(
    parameter int DATA_W = 32,
    parameter int FM_W   = 6,
    parameter int FM_H   = 6
) (
    input  logic      clk,
    input  logic      rst,
    pool2d_if.slave   bus
);
    localparam int OUT_W = FM_W / 2;
    localparam int OUT_H = FM_H / 2;
    localparam int COL_W = $clog2(FM_W);
    localparam int ROW_W = $clog2(FM_H);

    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(FM_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(FM_H - 1);
    localparam logic [COL_W-1:0] WIN_COL_LAST = COL_W'(2 * OUT_W - 1);
    localparam logic [ROW_W-1:0] WIN_ROW_LAST = ROW_W'(2 * OUT_H - 1);

    logic [COL_W-1:0]         col;
    logic [ROW_W-1:0]         row;
    logic                     mode_q;
    logic signed [DATA_W-1:0] left;
    logic signed [DATA_W-1:0] row_buf [FM_W];

    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_data_q;
    logic                     out_last_q;

    logic                     accept;
    logic                     win_done;
    logic                     win_final;
    logic signed [DATA_W-1:0] top_l;
    logic signed [DATA_W-1:0] top_r;
    logic signed [DATA_W+1:0] sum;
    logic signed [DATA_W-1:0] avg;
    logic signed [DATA_W-1:0] max_top;
    logic signed [DATA_W-1:0] max_bot;
    logic signed [DATA_W-1:0] max_all;
    logic signed [DATA_W-1:0] result;

    assign bus.in_ready   = !out_valid_q || bus.out_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_last   = out_last_q;
    assign bus.frame_done = out_valid_q && bus.out_ready && out_last_q;

    assign accept = bus.in_valid && bus.in_ready;
    // Odd row + odd col closes a window; a trailing odd column/row never does.
    assign win_done  = accept && row[0] && col[0];
    assign win_final = (row == WIN_ROW_LAST) && (col == WIN_COL_LAST);

    always_comb begin
        // col is odd whenever the window result is used, so col-1 is its even partner.
        top_l   = row_buf[col - COL_W'(1)];
        top_r   = row_buf[col];
        sum     = {{2{top_l[DATA_W-1]}}, top_l} + {{2{top_r[DATA_W-1]}}, top_r}
                + {{2{left[DATA_W-1]}}, left}   + {{2{bus.in_data[DATA_W-1]}}, bus.in_data};
        avg     = DATA_W'(sum >>> 2);
        max_top = (top_r > top_l) ? top_r : top_l;
        max_bot = (bus.in_data > left) ? bus.in_data : left;
        max_all = (max_bot > max_top) ? max_bot : max_top;
        result  = mode_q ? max_all : avg;
    end

    // NOTE: the row buffer has no reset; every entry is written on an even row
    // before any odd-row window reads it, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (accept && !row[0]) begin
            row_buf[col] <= bus.in_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col         <= '0;
            row         <= '0;
            mode_q      <= 1'b0;
            left        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (accept) begin
                if (row == '0 && col == '0) begin
                    mode_q <= bus.mode;
                end
                if (row[0] && !col[0]) begin
                    left <= bus.in_data;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end

            // A completing window can only occur when in_ready is high, i.e.
            // when any pending beat is being taken this same cycle.
            if (win_done) begin
                out_valid_q <= 1'b1;
                out_data_q  <= result;
                out_last_q  <= win_final;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end
endmodule
